// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared widths, PC command select encoding and sequencer state encoding
//   for the program-counter sequencer and its bus interface.
//   No ports; imported by pc_sequencer_if and pc_sequencer.
package pc_sequencer_pkg;

    localparam int ADDR_W     = 19;
    localparam int INSTR_W    = 19;
    localparam int CNT_W      = 16;
    localparam int LOAD_SEL_W = 2;

    typedef enum logic [LOAD_SEL_W-1:0] {
        LOAD_NONE = 2'd0,
        LOAD_PC   = 2'd1
    } load_sel_t;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_INC   = 3'd3,
        S_LOAD  = 3'd4,
        S_HALT  = 3'd5
    } seq_state_t;

    // One PC command: the three control lines driven together.
    typedef struct packed {
        logic      load_reg;
        load_sel_t load_select;
        logic      inc_pc;
    } pc_cmd_t;

    localparam pc_cmd_t CMD_CLEAR = '{load_reg: 1'b0, load_select: LOAD_PC,   inc_pc: 1'b0};
    localparam pc_cmd_t CMD_INC   = '{load_reg: 1'b0, load_select: LOAD_PC,   inc_pc: 1'b1};
    localparam pc_cmd_t CMD_LOAD  = '{load_reg: 1'b1, load_select: LOAD_PC,   inc_pc: 1'b0};
    localparam pc_cmd_t CMD_HOLD  = '{load_reg: 1'b0, load_select: LOAD_NONE, inc_pc: 1'b0};

    // PC command is a pure function of the sequencer state (Moore output).
    function automatic pc_cmd_t state_cmd(input seq_state_t s);
        case (s)
            S_RESET: return CMD_CLEAR;
            S_INC:   return CMD_INC;
            S_LOAD:  return CMD_LOAD;
            default: return CMD_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles every non-clock signal between the sequencer and its neighbours:
//     PC control      : LOAD_REG, LOAD_SELECT, INC_PC, PC_TARGET (out), PC_VALUE (in)
//     fetch handshake : MEM_REQ, MEM_ADDR (out), MEM_ACK, MEM_DATA (in)
//     execute         : IR, INSTR_VALID (out), EXEC_DONE, BR_TAKEN, BR_TARGET, HALT_REQ (in)
//     status          : HALTED, RETIRED (out)
//   master = sequencer side, slave = PC / memory / datapath side.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic               LOAD_REG;
    load_sel_t          LOAD_SELECT;
    logic               INC_PC;
    logic [ADDR_W-1:0]  PC_TARGET;
    logic [ADDR_W-1:0]  PC_VALUE;

    logic               MEM_REQ;
    logic [ADDR_W-1:0]  MEM_ADDR;
    logic               MEM_ACK;
    logic [INSTR_W-1:0] MEM_DATA;

    logic [INSTR_W-1:0] IR;
    logic               INSTR_VALID;
    logic               EXEC_DONE;
    logic               BR_TAKEN;
    logic [ADDR_W-1:0]  BR_TARGET;
    logic               HALT_REQ;

    logic               HALTED;
    logic [CNT_W-1:0]   RETIRED;

    modport master (
        output LOAD_REG, LOAD_SELECT, INC_PC, PC_TARGET,
        input  PC_VALUE,
        output MEM_REQ, MEM_ADDR,
        input  MEM_ACK, MEM_DATA,
        output IR, INSTR_VALID,
        input  EXEC_DONE, BR_TAKEN, BR_TARGET, HALT_REQ,
        output HALTED, RETIRED
    );

    modport slave (
        input  LOAD_REG, LOAD_SELECT, INC_PC, PC_TARGET,
        output PC_VALUE,
        input  MEM_REQ, MEM_ADDR,
        output MEM_ACK, MEM_DATA,
        input  IR, INSTR_VALID,
        output EXEC_DONE, BR_TAKEN, BR_TARGET, HALT_REQ,
        input  HALTED, RETIRED
    );

endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch/execute sequencer driving the program counter's control lines.
//   Fetches the instruction at PC_VALUE through MEM_REQ/MEM_ACK, holds it in
//   IR while the datapath executes, then increments the PC or loads a
//   latched branch target. A halt parks the sequencer until reset.
//   Ports:
//     CLK  - system clock, rising edge
//     RST  - asynchronous active-high reset
//     bus  - pc_sequencer_if.master (PC control, fetch, execute, status)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RESET | CLEAR driven to the PC; one cycle after reset release
//   S_FETCH | MEM_REQ at PC_VALUE, waiting for MEM_ACK
//   S_EXEC  | IR valid, waiting for EXEC_DONE
//   S_INC   | INC driven to the PC for one cycle
//   S_LOAD  | LOAD driven with the latched branch target for one cycle
//   S_HALT  | parked with HALTED=1 until reset
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    pc_sequencer_if.master bus
);

    seq_state_t         state_q,   state_d;
    logic [INSTR_W-1:0] ir_q,      ir_d;
    logic [ADDR_W-1:0]  target_q,  target_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    pc_cmd_t            cmd;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_RESET;
            ir_q      <= '0;
            target_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            target_q  <= target_d;
            retired_q <= retired_d;
        end
    end

    // Handshake inputs are only looked at in the state that owns them, so
    // a stray ACK during execute or a stray DONE during fetch has no effect.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        target_d  = target_q;
        retired_d = retired_q;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                if (bus.MEM_ACK) begin
                    ir_d    = bus.MEM_DATA;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (bus.EXEC_DONE) begin
                    retired_d = retired_q + CNT_W'(1);
                    // Halt wins over a branch; the target register is left
                    // untouched so no load is ever pending behind a halt.
                    if (bus.HALT_REQ) begin
                        state_d = S_HALT;
                    end else if (bus.BR_TAKEN) begin
                        target_d = bus.BR_TARGET;
                        state_d  = S_LOAD;
                    end else begin
                        state_d = S_INC;
                    end
                end
            end

            S_INC:   state_d = S_FETCH;
            S_LOAD:  state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // All handshake and PC command outputs decode straight from the state,
    // so an asynchronous reset removes MEM_REQ / INSTR_VALID immediately.
    assign cmd             = state_cmd(state_q);
    assign bus.LOAD_REG    = cmd.load_reg;
    assign bus.LOAD_SELECT = cmd.load_select;
    assign bus.INC_PC      = cmd.inc_pc;
    assign bus.PC_TARGET   = target_q;

    assign bus.MEM_REQ     = (state_q == S_FETCH);
    assign bus.MEM_ADDR    = bus.PC_VALUE;

    assign bus.IR          = ir_q;
    assign bus.INSTR_VALID = (state_q == S_EXEC);

    assign bus.HALTED      = (state_q == S_HALT);
    assign bus.RETIRED     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic CLK = 1'b0;
    logic rst_main = 1'b1;
    logic rst_coll = 1'b0;
    wire  RST = rst_main | rst_coll;

    always #5 CLK = ~CLK;

    pc_sequencer_if bus();
    pc_sequencer dut (.CLK(CLK), .RST(RST), .bus(bus));

    int checks = 0;
    int errors = 0;

    // scoreboard queues
    logic [ADDR_W-1:0]  exp_addr[$];
    logic [INSTR_W-1:0] exp_ir[$];
    logic [ADDR_W-1:0]  exp_tgt[$];
    int                 exp_len[$];
    int                 exp_per[$];

    // reference program model
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_tgt;
    int                m_ret;
    bit                m_halt;
    int                n_done;
    int                cur_mw;

    // phase configuration (written by main only)
    bit mem_en = 1'b1;
    bit spur = 1'b0;
    bit collide = 1'b0;
    bit force_first = 1'b0;
    int mem_wait_cfg = 0;
    int ex_wait_cfg = 0;
    int br_pct = 0;
    int halt_at = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural program counter: responds to the command lines.
    initial begin
        bus.PC_VALUE = '0;
        forever begin
            @(posedge CLK);
            if (bus.LOAD_REG && bus.LOAD_SELECT == LOAD_PC)
                bus.PC_VALUE <= bus.PC_TARGET;
            else if (bus.INC_PC)
                bus.PC_VALUE <= ADDR_W'(bus.PC_VALUE + 1'b1);
            else if (bus.LOAD_SELECT == LOAD_PC)
                bus.PC_VALUE <= '0;
        end
    end

    // Instruction memory responder.
    initial begin
        int cnt;
        int w;
        cnt = 0;
        w = 0;
        bus.MEM_ACK  = 1'b0;
        bus.MEM_DATA = '0;
        forever begin
            @(negedge CLK);
            if (rst_main) rst_coll = 1'b0;
            if (RST) cnt = 0;
            if (mem_en) begin
                bus.MEM_ACK = 1'b0;
                if (!RST && bus.MEM_REQ && collide) begin
                    bus.MEM_ACK  = 1'b1;
                    bus.MEM_DATA = INSTR_W'($urandom);
                    rst_coll     = 1'b1;
                end else if (!RST && bus.MEM_REQ) begin
                    if (cnt == 0) begin
                        w = (mem_wait_cfg < 0) ? int'($urandom_range(3, 0)) : mem_wait_cfg;
                        exp_len.push_back(w + 1);
                    end
                    if (cnt == w) begin
                        bus.MEM_ACK  = 1'b1;
                        bus.MEM_DATA = INSTR_W'($urandom);
                        exp_ir.push_back(bus.MEM_DATA);
                        cur_mw = w;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else if (!RST && spur && bus.INSTR_VALID) begin
                    bus.MEM_ACK  = 1'b1;
                    bus.MEM_DATA = INSTR_W'($urandom);
                end
            end
        end
    end

    // Datapath responder; every accepted DONE advances the reference model.
    initial begin
        int cnt;
        int w;
        bit hlt;
        bit br;
        logic [ADDR_W-1:0] tgt;
        cnt = 0;
        w = 0;
        bus.EXEC_DONE = 1'b0;
        bus.BR_TAKEN  = 1'b0;
        bus.HALT_REQ  = 1'b0;
        bus.BR_TARGET = '0;
        forever begin
            @(negedge CLK);
            bus.EXEC_DONE = 1'b0;
            bus.BR_TAKEN  = 1'b0;
            bus.HALT_REQ  = 1'b0;
            bus.BR_TARGET = ADDR_W'($urandom);
            if (RST) begin
                cnt = 0;
                m_pc = '0; m_tgt = '0; m_ret = 0; m_halt = 1'b0; n_done = 0;
            end else if (bus.INSTR_VALID) begin
                if (cnt == 0) w = (ex_wait_cfg < 0) ? int'($urandom_range(3, 0)) : ex_wait_cfg;
                if (cnt == w) begin
                    cnt = 0;
                    n_done++;
                    m_ret++;
                    hlt = (n_done == halt_at);
                    br  = hlt || (force_first && n_done == 1) || ($urandom_range(99, 0) < br_pct);
                    if (force_first && n_done == 1) tgt = 19'h1_2345;
                    else if ($urandom_range(3, 0) == 0) tgt = '1;
                    else tgt = ADDR_W'($urandom);
                    bus.EXEC_DONE = 1'b1;
                    bus.BR_TAKEN  = br;
                    bus.HALT_REQ  = hlt;
                    bus.BR_TARGET = tgt;
                    if (hlt) begin
                        m_halt = 1'b1;
                    end else begin
                        if (br) begin
                            m_tgt = tgt;
                            m_pc  = tgt;
                            exp_tgt.push_back(tgt);
                        end else begin
                            m_pc = ADDR_W'(m_pc + 1'b1);
                        end
                        exp_addr.push_back(m_pc);
                        exp_per.push_back(cur_mw + w + 3);
                    end
                end else begin
                    cnt++;
                end
            end else if (spur && bus.MEM_REQ) begin
                bus.EXEC_DONE = 1'b1;
                bus.BR_TAKEN  = 1'b1;
                bus.HALT_REQ  = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transaction.
    initial begin
        bit prev_req, prev_iv, prev_load, prev_halt, have_fetch;
        int len, last_start, cyc;
        logic [ADDR_W-1:0]  fa;
        logic [INSTR_W-1:0] cur_ir;
        prev_req = 0; prev_iv = 0; prev_load = 0; prev_halt = 0; have_fetch = 0;
        len = 0; last_start = 0; cyc = 0; fa = '0; cur_ir = '0;
        forever begin
            @(posedge CLK);
            #2;
            cyc++;
            if (RST) begin
                prev_req = 0; prev_iv = 0; prev_load = 0; prev_halt = 0; have_fetch = 0;
                continue;
            end
            if (bus.INC_PC)
                chk("inc_cmd", 32'({bus.LOAD_REG, bus.LOAD_SELECT}), 32'({1'b0, LOAD_PC}));
            if (bus.MEM_REQ && !prev_req) begin
                chk("fetch_expected", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0) chk("fetch_addr", 32'(bus.MEM_ADDR), 32'(exp_addr.pop_front()));
                chk("retired_at_fetch", 32'(bus.RETIRED), 32'(m_ret[CNT_W-1:0]));
                if (have_fetch && exp_per.size() > 0)
                    chk("period", 32'(cyc - last_start), 32'(exp_per.pop_front()));
                have_fetch = 1; last_start = cyc; len = 0; fa = bus.MEM_ADDR;
            end
            if (bus.MEM_REQ) begin
                len++;
                chk("addr_stable", 32'(bus.MEM_ADDR), 32'(fa));
            end
            if (!bus.MEM_REQ && prev_req) begin
                chk("req_len_expected", 32'(exp_len.size() > 0), 32'd1);
                if (exp_len.size() > 0) chk("req_len", 32'(len), 32'(exp_len.pop_front()));
            end
            if (bus.INSTR_VALID && !prev_iv) begin
                chk("ir_expected", 32'(exp_ir.size() > 0), 32'd1);
                if (exp_ir.size() > 0) cur_ir = exp_ir.pop_front();
            end
            if (bus.INSTR_VALID) chk("ir", 32'(bus.IR), 32'(cur_ir));
            if (bus.LOAD_REG) begin
                chk("load_one_cycle", 32'(prev_load), 32'd0);
                chk("load_expected", 32'(exp_tgt.size() > 0), 32'd1);
                if (exp_tgt.size() > 0) chk("pc_target", 32'(bus.PC_TARGET), 32'(exp_tgt.pop_front()));
            end
            if (bus.HALTED && !prev_halt) begin
                chk("halt_expected", 32'(m_halt), 32'd1);
                chk("retired_at_halt", 32'(bus.RETIRED), 32'(m_ret[CNT_W-1:0]));
                chk("target_hold", 32'(bus.PC_TARGET), 32'(m_tgt));
            end
            prev_req  = bus.MEM_REQ;
            prev_iv   = bus.INSTR_VALID;
            prev_load = bus.LOAD_REG;
            prev_halt = bus.HALTED;
        end
    end

    task automatic start_phase(input int mw, input int ew, input int brp, input int hat,
                               input bit ffb, input bit sp);
        @(posedge CLK); #1;
        rst_main = 1'b1;
        collide  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_mem_req", 32'(bus.MEM_REQ), 32'd0);
        chk("rst_ir", 32'(bus.IR), 32'd0);
        chk("rst_instr_valid", 32'(bus.INSTR_VALID), 32'd0);
        chk("rst_halted", 32'(bus.HALTED), 32'd0);
        chk("rst_retired", 32'(bus.RETIRED), 32'd0);
        chk("rst_pc_target", 32'(bus.PC_TARGET), 32'd0);
        chk("rst_clear_cmd", 32'({bus.LOAD_REG, bus.LOAD_SELECT, bus.INC_PC}), 32'({1'b0, LOAD_PC, 1'b0}));
        chk("rst_pc_value", 32'(bus.PC_VALUE), 32'd0);
        exp_addr.delete(); exp_ir.delete(); exp_tgt.delete(); exp_len.delete(); exp_per.delete();
        mem_wait_cfg = mw; ex_wait_cfg = ew; br_pct = brp; halt_at = hat;
        force_first = ffb; spur = sp; mem_en = 1'b1;
        exp_addr.push_back('0);
        rst_main = 1'b0;
        #1 chk("no_req_in_clear_cycle", 32'(bus.MEM_REQ), 32'd0);
        @(posedge CLK); #2;
        chk("first_req", 32'(bus.MEM_REQ), 32'd1);
    endtask

    task automatic wait_halt(input int budget);
        int i;
        i = 0;
        while (!bus.HALTED && i < budget) begin
            @(posedge CLK); #1;
            i++;
        end
        chk("halt_reached", 32'(bus.HALTED), 32'd1);
        repeat (6) @(posedge CLK);
        #1;
        chk("halt_sticky", 32'(bus.HALTED), 32'd1);
        chk("no_req_after_halt", 32'(bus.MEM_REQ), 32'd0);
    endtask

    initial begin
        int i;
        // zero-wait run: fetches at 0,1,2,3 on a 3-cycle period
        start_phase(0, 0, 0, 4, 1'b0, 1'b0);
        wait_halt(200);
        // 4 memory wait states: MEM_REQ high for 5 cycles per fetch
        start_phase(4, 0, 0, 3, 1'b0, 1'b0);
        wait_halt(200);
        // forced branch to 0x1_2345 then random branches, halt with branch
        start_phase(0, 1, 30, 6, 1'b1, 1'b0);
        wait_halt(300);
        // random waits and branches
        start_phase(-1, -1, 25, 40, 1'b0, 1'b0);
        wait_halt(2000);
        // spurious ACK during execute, spurious DONE/BR/HALT during fetch
        start_phase(3, 2, 0, 4, 1'b0, 1'b1);
        wait_halt(300);
        // reset collides with an ACK mid-fetch
        start_phase(0, 0, 0, 100, 1'b0, 1'b0);
        i = 0;
        while (!(bus.RETIRED >= CNT_W'(2) && !bus.MEM_REQ) && i < 200) begin
            @(posedge CLK); #1;
            i++;
        end
        collide = 1'b1;
        i = 0;
        while (!RST && i < 50) begin
            @(negedge CLK); #1;
            i++;
        end
        chk("collide_rst_seen", 32'(RST), 32'd1);
        chk("collide_mem_req", 32'(bus.MEM_REQ), 32'd0);
        chk("collide_ir", 32'(bus.IR), 32'd0);
        chk("collide_instr_valid", 32'(bus.INSTR_VALID), 32'd0);
        chk("collide_retired", 32'(bus.RETIRED), 32'd0);
        start_phase(0, 0, 20, 5, 1'b0, 1'b0);
        wait_halt(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
